regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port register file with an integrated pending-write scoreboard. It serves as the register file for the pipelined core. It provides NUM_RD combinational read ports and NUM_WR synchronous write ports, with register 0 hardwired to zero. Per-register busy bits let decode detect RAW hazards against in-flight writebacks.

## Interface
- DATA_W, 32: register width in bits.
- ADDR_W, 5: address width; DEPTH = 2**ADDR_W registers.
- NUM_RD, 2: number of read ports, at least 1.
- NUM_WR, 2: number of write ports, at least 1.
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- wr_en  input  NUM_WR  per-port write enable.
- wr_addr  input  NUM_WR*ADDR_W  write addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
- wr_data  input  NUM_WR*DATA_W  write data, packed the same way.
- rd_addr  input  NUM_RD*ADDR_W  read addresses, packed.
- rd_data  output  NUM_RD*DATA_W  read data, packed.
- rd_busy  output  NUM_RD  1 when the register addressed by rd_addr is marked pending.
- sb_set  input  1  marks sb_addr pending (instruction issue).
- sb_addr  input  ADDR_W  destination register being issued.
- flush  input  1  synchronously clears all busy bits.

## Operation
- Storage:
  - DEPTH x DATA_W flops.
  - Register 0 is not stored. Reads of address 0 return 0, and rd_busy for address 0 is 0.
  - Writes and sb_set to address 0 are ignored.
- Write:
  - On the rising edge, each port i with wr_en[i]=1 and a nonzero address writes wr_data[i].
  - If several ports target the same address in one cycle, the highest-indexed port wins.
- Scoreboard, one busy bit per register, updated on the rising edge in this priority order:
  1. flush=1: all bits clear. sb_set in the same cycle is ignored.
  2. Otherwise, any enabled write to address A clears busy[A].
  3. sb_set=1 sets busy[sb_addr]. Set wins over a same-cycle write clear to the same address, because the newly issued instruction owns it.
- Read:
  - rd_data and rd_busy are purely combinational from rd_addr and state, plus the bypass path when it is enabled.
  - Port j returns reg[rd_addr_j] (after bypass) and busy[rd_addr_j].
  - When bypass is enabled and a same-cycle write matches the read address, rd_busy is also forced to 0 for that port, unless sb_set targets the same address in that cycle.
- Reset (reset=0, asynchronous):
  - All registers are 0 and all busy bits are 0.
  - rd_data is therefore 0 and rd_busy 0 for every address while reset is held.
  - Asserting reset mid-write discards the write.
- No width conversion is performed; data passes bit-exact.

## Timing
- Write latency: data is visible on a read port one cycle after the write edge, or in the same cycle with bypass enabled.
- Read latency: 0 cycles (combinational).
- Busy set: sb_set at edge N means rd_busy=1 for that address from after edge N until the clearing write's edge.
- Busy clear: a write at edge M means rd_busy=0 after edge M, or during the cycle before edge M with bypass enabled.
- Reset deassertion is synchronised externally. The first write can occur on the first rising edge with reset=1.

## Configuration
- REGFILE_BYPASS_EN:
  - Defined: write-first forwarding. A read whose address matches an enabled, nonzero-address write in the same cycle returns that write's data (highest-indexed matching port), with rd_busy suppressed as described in Operation.
  - Undefined: reads return the stored value only (read-old). rd_busy reflects the stored busy bits only.

## Test plan
- Reset, then write reg4=12 (port 0) and reg5=6 (port 1) in the same cycle; next cycle read rd_addr=4,5 -> rd_data=12,6, rd_busy=0,0.
- Write reg0=0xDEADBEEF from port 0; read address 0 -> 0. Issue sb_set at address 0 -> rd_busy=0.
- Both ports write reg7 in the same cycle (port 0=1, port 1=2); next cycle read reg7 -> 2.
- With REGFILE_BYPASS_EN, write reg4=15 while reading reg4 (old value 12) -> 15 in the same cycle. Without the macro -> 12 that cycle, then 15 the next.
- sb_set reg9 at edge N -> rd_busy=1. Write reg9 at edge N+3 -> rd_busy=0 after it. In the same test, sb_set reg9 while writing reg9 -> rd_busy stays 1.
- Set busy on reg3 and reg6, assert flush together with sb_set reg8 -> all rd_busy=0 next cycle. Then drive reset=0 mid-write -> every register reads 0 immediately.

Source files
------------

// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - register file port bundle: write ports, read ports, scoreboard controls
interface regfile_mp_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2,
   parameter int NUM_WR = 2
);
   logic [NUM_WR-1:0]        wr_en;
   logic [NUM_WR*ADDR_W-1:0] wr_addr;
   logic [NUM_WR*DATA_W-1:0] wr_data;
   logic [NUM_RD*ADDR_W-1:0] rd_addr;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic [NUM_RD-1:0]        rd_busy;
   logic                     sb_set;
   logic [ADDR_W-1:0]        sb_addr;
   logic                     flush;

   modport master (
      output wr_en, wr_addr, wr_data, rd_addr, sb_set, sb_addr, flush,
      input  rd_data, rd_busy
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, rd_addr, sb_set, sb_addr, flush,
      output rd_data, rd_busy
   );
endinterface

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with pending-write scoreboard; REGFILE_BYPASS_EN enables write-first forwarding
module regfile_mp #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2,
   parameter int NUM_WR = 2
) (
   input logic         clk,
   input logic         reset,
   regfile_mp_if.slave bus
);
   localparam int DEPTH = 2 ** ADDR_W;

   // Register 0 has no storage; index range starts at 1.
   logic [DATA_W-1:0]        regs [1:DEPTH-1];
   logic [DEPTH-1:1]         busy;
   logic [DEPTH-1:1]         busy_nxt;
   logic [NUM_RD*DATA_W-1:0] rd_data_c;
   logic [NUM_RD-1:0]        rd_busy_c;
   logic [ADDR_W-1:0]        sb_wa;
   logic [ADDR_W-1:0]        rd_ra;
`ifdef REGFILE_BYPASS_EN
   logic [ADDR_W-1:0]        rd_wa;
`endif

   always_comb begin
      busy_nxt = busy;
      sb_wa    = '0;
      if (bus.flush) begin
         busy_nxt = '0;
      end else begin
         for (int i = 0; i < NUM_WR; i++) begin
            sb_wa = bus.wr_addr[i*ADDR_W +: ADDR_W];
            if (bus.wr_en[i] && sb_wa != '0)
               busy_nxt[sb_wa] = 1'b0;
         end
         // Issue wins over a same-cycle writeback: the new instruction owns the register.
         if (bus.sb_set && bus.sb_addr != '0)
            busy_nxt[bus.sb_addr] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 1; k < DEPTH; k++)
            regs[k] <= '0;
         busy <= '0;
      end else begin
         // Ascending loop: the highest-indexed port's assignment lands last.
         for (int i = 0; i < NUM_WR; i++) begin
            if (bus.wr_en[i] && bus.wr_addr[i*ADDR_W +: ADDR_W] != '0)
               regs[bus.wr_addr[i*ADDR_W +: ADDR_W]] <= bus.wr_data[i*DATA_W +: DATA_W];
         end
         busy <= busy_nxt;
      end
   end

   always_comb begin
      rd_data_c = '0;
      rd_busy_c = '0;
      rd_ra     = '0;
`ifdef REGFILE_BYPASS_EN
      rd_wa     = '0;
`endif
      for (int j = 0; j < NUM_RD; j++) begin
         rd_ra = bus.rd_addr[j*ADDR_W +: ADDR_W];
         if (rd_ra != '0) begin
            rd_data_c[j*DATA_W +: DATA_W] = regs[rd_ra];
            rd_busy_c[j]                  = busy[rd_ra];
`ifdef REGFILE_BYPASS_EN
            // Forwarding is gated by reset so reads stay zero while reset is held.
            for (int i = 0; i < NUM_WR; i++) begin
               rd_wa = bus.wr_addr[i*ADDR_W +: ADDR_W];
               if (reset && bus.wr_en[i] && rd_wa == rd_ra) begin
                  rd_data_c[j*DATA_W +: DATA_W] = bus.wr_data[i*DATA_W +: DATA_W];
                  if (!(bus.sb_set && bus.sb_addr == rd_ra))
                     rd_busy_c[j] = 1'b0;
               end
            end
`endif
         end
      end
   end

   assign bus.rd_data = rd_data_c;
   assign bus.rd_busy = rd_busy_c;
endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - randomized and directed self-checking bench for regfile_mp against an array model
module tb_regfile_mp;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 2;
   localparam int NW = 2;
   localparam int DEPTH = 32;

   logic clk;
   logic reset;

   regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) bus ();

   regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_err = 0;

   logic        t_wr_en   [NW];
   int          t_wr_addr [NW];
   logic [31:0] t_wr_data [NW];
   int          t_rd_addr [NR];
   logic        t_sb_set;
   int          t_sb_addr;
   logic        t_flush;

   logic [31:0] m_regs [DEPTH];
   logic        m_busy [DEPTH];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int a = 0; a < DEPTH; a++) begin
         m_regs[a] = '0;
         m_busy[a] = 1'b0;
      end
   endtask

   task automatic idle();
      for (int i = 0; i < NW; i++) begin
         t_wr_en[i] = 1'b0; t_wr_addr[i] = 0; t_wr_data[i] = '0;
      end
      for (int j = 0; j < NR; j++) t_rd_addr[j] = 0;
      t_sb_set = 1'b0; t_sb_addr = 0; t_flush = 1'b0;
   endtask

   task automatic apply();
      for (int i = 0; i < NW; i++) begin
         bus.wr_en[i]             = t_wr_en[i];
         bus.wr_addr[i*AW +: AW]  = AW'(t_wr_addr[i]);
         bus.wr_data[i*DW +: DW]  = t_wr_data[i];
      end
      for (int j = 0; j < NR; j++) bus.rd_addr[j*AW +: AW] = AW'(t_rd_addr[j]);
      bus.sb_set  = t_sb_set;
      bus.sb_addr = AW'(t_sb_addr);
      bus.flush   = t_flush;
   endtask

   function automatic logic [31:0] exp_data(input int a);
      if (!reset || a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
      for (int i = NW - 1; i >= 0; i--)
         if (t_wr_en[i] && t_wr_addr[i] == a) return t_wr_data[i];
`endif
      return m_regs[a];
   endfunction

   function automatic logic exp_busy(input int a);
      if (!reset || a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
      for (int i = 0; i < NW; i++)
         if (t_wr_en[i] && t_wr_addr[i] == a && !(t_sb_set && t_sb_addr == a)) return 1'b0;
`endif
      return m_busy[a];
   endfunction

   task automatic model_update();
      if (t_flush) begin
         for (int a = 0; a < DEPTH; a++) m_busy[a] = 1'b0;
      end else begin
         for (int i = 0; i < NW; i++)
            if (t_wr_en[i] && t_wr_addr[i] != 0) m_busy[t_wr_addr[i]] = 1'b0;
         if (t_sb_set && t_sb_addr != 0) m_busy[t_sb_addr] = 1'b1;
      end
      for (int i = 0; i < NW; i++)
         if (t_wr_en[i] && t_wr_addr[i] != 0) m_regs[t_wr_addr[i]] = t_wr_data[i];
   endtask

   task automatic peek();
      apply();
      #1;
   endtask

   task automatic cycle();
      apply();
      #1;
      for (int j = 0; j < NR; j++) begin
         chk($sformatf("rd_data[%0d] a=%0d", j, t_rd_addr[j]), bus.rd_data[j*DW +: DW], exp_data(t_rd_addr[j]));
         chk($sformatf("rd_busy[%0d] a=%0d", j, t_rd_addr[j]), 32'(bus.rd_busy[j]), 32'(exp_busy(t_rd_addr[j])));
      end
      @(posedge clk);
      if (reset) model_update();
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b0;
      idle();
      model_clear();
      t_rd_addr[0] = 4; t_rd_addr[1] = 5;
      peek();
      chk("reset rd_data0", bus.rd_data[0 +: DW], 32'd0);
      chk("reset rd_busy", 32'(bus.rd_busy), 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;

      // two ports, distinct addresses
      idle();
      t_wr_en[0] = 1'b1; t_wr_addr[0] = 4; t_wr_data[0] = 32'd12;
      t_wr_en[1] = 1'b1; t_wr_addr[1] = 5; t_wr_data[1] = 32'd6;
      cycle();
      idle(); t_rd_addr[0] = 4; t_rd_addr[1] = 5;
      peek();
      chk("wr4 data", bus.rd_data[0 +: DW], 32'd12);
      chk("wr5 data", bus.rd_data[DW +: DW], 32'd6);
      chk("wr45 busy", 32'(bus.rd_busy), 32'd0);
      cycle();

      // register 0 ignores writes and issue
      idle();
      t_wr_en[0] = 1'b1; t_wr_addr[0] = 0; t_wr_data[0] = 32'hDEADBEEF;
      t_sb_set = 1'b1; t_sb_addr = 0;
      cycle();
      idle();
      peek();
      chk("r0 data", bus.rd_data[0 +: DW], 32'd0);
      chk("r0 busy", 32'(bus.rd_busy[0]), 32'd0);
      cycle();

      // same-address collision, highest port wins
      idle();
      t_wr_en[0] = 1'b1; t_wr_addr[0] = 7; t_wr_data[0] = 32'd1;
      t_wr_en[1] = 1'b1; t_wr_addr[1] = 7; t_wr_data[1] = 32'd2;
      cycle();
      idle(); t_rd_addr[0] = 7;
      peek();
      chk("r7 collision", bus.rd_data[0 +: DW], 32'd2);
      cycle();

      // same-cycle read of a write in flight
      idle();
      t_wr_en[0] = 1'b1; t_wr_addr[0] = 4; t_wr_data[0] = 32'd15; t_rd_addr[0] = 4;
      peek();
`ifdef REGFILE_BYPASS_EN
      chk("r4 same cycle", bus.rd_data[0 +: DW], 32'd15);
`else
      chk("r4 same cycle", bus.rd_data[0 +: DW], 32'd12);
`endif
      cycle();
      idle(); t_rd_addr[0] = 4;
      peek();
      chk("r4 next cycle", bus.rd_data[0 +: DW], 32'd15);
      cycle();

      // busy lifetime on reg9
      idle(); t_sb_set = 1'b1; t_sb_addr = 9;
      cycle();
      idle(); t_rd_addr[0] = 9;
      peek();
      chk("r9 busy set", 32'(bus.rd_busy[0]), 32'd1);
      cycle();
      cycle();
      t_wr_en[0] = 1'b1; t_wr_addr[0] = 9; t_wr_data[0] = 32'h99;
      peek();
`ifdef REGFILE_BYPASS_EN
      chk("r9 busy write cycle", 32'(bus.rd_busy[0]), 32'd0);
`else
      chk("r9 busy write cycle", 32'(bus.rd_busy[0]), 32'd1);
`endif
      cycle();
      idle(); t_rd_addr[0] = 9;
      peek();
      chk("r9 busy cleared", 32'(bus.rd_busy[0]), 32'd0);
      t_sb_set = 1'b1; t_sb_addr = 9;
      t_wr_en[1] = 1'b1; t_wr_addr[1] = 9; t_wr_data[1] = 32'h77;
      cycle();
      idle(); t_rd_addr[0] = 9;
      peek();
      chk("r9 set beats clear", 32'(bus.rd_busy[0]), 32'd1);
      cycle();

      // flush overrides a same-cycle issue
      idle(); t_sb_set = 1'b1; t_sb_addr = 3;
      cycle();
      t_sb_addr = 6;
      cycle();
      idle(); t_rd_addr[0] = 3; t_rd_addr[1] = 6;
      peek();
      chk("r3 r6 busy", 32'(bus.rd_busy), 32'd3);
      t_flush = 1'b1; t_sb_set = 1'b1; t_sb_addr = 8;
      cycle();
      idle(); t_rd_addr[0] = 3; t_rd_addr[1] = 6;
      peek();
      chk("flush r3 r6", 32'(bus.rd_busy), 32'd0);
      cycle();
      t_rd_addr[0] = 8;
      peek();
      chk("flush r8", 32'(bus.rd_busy[0]), 32'd0);
      cycle();

      // randomized traffic on a narrow address window to provoke collisions
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < NW; i++) begin
            t_wr_en[i]   = 1'($urandom_range(0, 1));
            t_wr_addr[i] = int'($urandom_range(0, 15));
            t_wr_data[i] = $urandom;
         end
         for (int j = 0; j < NR; j++) t_rd_addr[j] = int'($urandom_range(0, 15));
         t_sb_set  = 1'($urandom_range(0, 1));
         t_sb_addr = int'($urandom_range(0, 15));
         t_flush   = ($urandom_range(0, 15) == 0);
         cycle();
      end

      // asynchronous reset in the middle of a write
      idle();
      t_wr_en[0] = 1'b1; t_wr_addr[0] = 10; t_wr_data[0] = 32'h1234;
      t_sb_set = 1'b1; t_sb_addr = 10;
      apply();
      reset = 1'b0;
      model_clear();
      for (int a = 0; a < DEPTH; a++) begin
         t_rd_addr[0] = a; t_rd_addr[1] = DEPTH - 1 - a;
         peek();
         chk($sformatf("reset data a=%0d", a), bus.rd_data[0 +: DW], 32'd0);
         chk($sformatf("reset busy a=%0d", a), 32'(bus.rd_busy), 32'd0);
      end
      @(negedge clk);
      idle();
      reset = 1'b1;
      t_rd_addr[0] = 10; t_rd_addr[1] = 4;
      cycle();
      cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
